// File: rtl/freq_search_ctrl.sv
// rtl/freq_search_ctrl.sv - control FSM sequencing the frequency-search datapath
module freq_search_ctrl #(
    parameter int ADDR_W   = 9,
    parameter int PIPE_LAT = 3,
    parameter int FREQ_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic abort,
    input  logic equal,
    input  logic over,
    output logic clrDp,
    output logic load,
    output logic running,
    output logic incFreq,
    output logic busy,
    output logic done,
    output logic sat
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    // A running cycle seen while the monitor already holds 2^ADDR_W is the
    // (2^ADDR_W+1)-th one: the address counter must have wrapped by now.
    localparam logic [ADDR_W+1:0] SCAN_LIMIT = (ADDR_W+2)'(2 ** ADDR_W);
    localparam logic [FREQ_W-1:0] FREQ_MAX   = '1;
    localparam logic [2:0]        DRAIN_LAST = 3'(PIPE_LAT - 1);

    state_t              state;
    logic [PIPE_LAT-1:0] vpipe;
    logic [2:0]          drain_cnt;
    logic [FREQ_W-1:0]   freq_cnt;
    logic [ADDR_W+1:0]   scan_cnt;
    logic                qual;

    assign qual = vpipe[PIPE_LAT-1];

    // Address advance stops in the very cycle the wrap flag is seen; a match
    // is only counted when its compare belongs to a real scanned address.
    always_comb begin
        running = (state == S_SCAN) && !over;
        incFreq = equal && qual && !sat && ((state == S_SCAN) || (state == S_DRAIN));
    end

    // Sequencer, valid pipe, match counter and registered phase outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            vpipe     <= '0;
            drain_cnt <= '0;
            freq_cnt  <= '0;
            scan_cnt  <= '0;
            sat       <= 1'b0;
            clrDp     <= 1'b0;
            load      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            vpipe <= (vpipe << 1) | PIPE_LAT'(running);

            if (incFreq) begin
                freq_cnt <= freq_cnt + 1'b1;
                if (freq_cnt == FREQ_MAX - 1'b1) begin
                    sat <= 1'b1;
                end
            end

            if (abort) begin
                state     <= S_IDLE;
                vpipe     <= '0;
                drain_cnt <= '0;
                scan_cnt  <= '0;
                clrDp     <= 1'b0;
                load      <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state <= S_CLEAR;
                            clrDp <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                    S_CLEAR: begin
                        freq_cnt <= '0;
                        sat      <= 1'b0;
                        vpipe    <= '0;
                        state    <= S_LOAD;
                        clrDp    <= 1'b0;
                        load     <= 1'b1;
                    end
                    S_LOAD: begin
                        scan_cnt <= '0;
                        state    <= S_SCAN;
                        load     <= 1'b0;
                    end
                    S_SCAN: begin
                        if (running) begin
                            scan_cnt <= scan_cnt + 1'b1;
                        end
                        if (over || (scan_cnt == SCAN_LIMIT)) begin
                            drain_cnt <= '0;
                            state     <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (drain_cnt == DRAIN_LAST) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 3'd1;
                        end
                    end
                    S_DONE: begin
                        if (start) begin
                            state <= S_CLEAR;
                            done  <= 1'b0;
                            clrDp <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        clrDp <= 1'b0;
                        load  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_freq_search_ctrl.sv
// tb/tb_freq_search_ctrl.sv - directed self-checking bench for freq_search_ctrl
module tb_freq_search_ctrl;

    localparam int SCAN_LEN = 512;

    logic clk = 1'b0;
    logic reset, start, abort, equal, over;
    logic clrDp, load, running, incFreq, busy, done, sat;

    int compared   = 0;
    int mismatched = 0;

    int cyc, eq_mode, run_cnt;
    int clr_at, load_at, first_run, done_at, inc_cnt, first_inc, last_inc;
    logic [6:0] sticky_or;

    freq_search_ctrl #(.ADDR_W(9), .PIPE_LAT(3), .FREQ_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .equal   (equal),
        .over    (over),
        .clrDp   (clrDp),
        .load    (load),
        .running (running),
        .incFreq (incFreq),
        .busy    (busy),
        .done    (done),
        .sat     (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic eq_fn(input int c);
        case (eq_mode)
            1: return (c == 11) || (c == 106) || (c == 517);
            2: return 1'b1;
            3: return (c <= 5) || (c >= 515 && c <= 519);
            4: return 1'($urandom_range(0, 1));
            5: return (c == 11);
            default: return 1'b0;
        endcase
    endfunction

    task automatic clear_obs();
        cyc = 0; clr_at = -1; load_at = -1; first_run = -1; done_at = -1;
        inc_cnt = 0; first_inc = -1; last_inc = -1; sticky_or = '0;
    endtask

    // One clock: drive the datapath model inputs after the edge, then observe.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        over  = (run_cnt == SCAN_LEN);
        equal = eq_fn(cyc);
        #1;
        if (clrDp && clr_at < 0)     clr_at = cyc;
        if (load && load_at < 0)     load_at = cyc;
        if (running && first_run < 0) first_run = cyc;
        if (done && done_at < 0)     done_at = cyc;
        if (incFreq) begin
            inc_cnt++;
            if (first_inc < 0) first_inc = cyc;
            last_inc = cyc;
        end
        if (running) run_cnt++;
        if (clrDp)   run_cnt = 0;
        sticky_or |= {clrDp, load, running, incFreq, busy, done, sat};
    endtask

    task automatic run_to_done();
        while (done_at < 0 && cyc < 700) step();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; equal = 1'b0; over = 1'b0;
        run_cnt = 0; eq_mode = 0;
        clear_obs();
        repeat (3) step();
        reset = 1'b0;
        check("reset_outputs", {25'd0, clrDp, load, running, incFreq, busy, done, sat}, 32'd0);

        // Idle with random equal: nothing may move.
        eq_mode = 4;
        clear_obs();
        repeat (10) step();
        check("idle_outputs", {25'd0, sticky_or}, 32'd0);

        // Search 1: matches on qualified slots 5, 100, 511.
        eq_mode = 1;
        clear_obs();
        start = 1'b1;
        step();
        start = 1'b0;
        run_to_done();
        check("s1_clr_at", clr_at, 1);
        check("s1_load_at", load_at, 2);
        check("s1_first_run", first_run, 3);
        check("s1_run_cycles", run_cnt, SCAN_LEN);
        check("s1_done_at", done_at, 519);
        check("s1_inc_cnt", inc_cnt, 3);
        check("s1_last_inc", last_inc, 517);
        check("s1_sat", sat, 0);
        check("s1_busy_in_done", busy, 0);

        // Search 2: equal stuck high, counter saturates at 255.
        eq_mode = 2;
        clear_obs();
        start = 1'b1;
        step();
        start = 1'b0;
        run_to_done();
        check("sat_inc_cnt", inc_cnt, 255);
        check("sat_first_inc", first_inc, 6);
        check("sat_last_inc", last_inc, 260);
        check("sat_flag", sat, 1);
        check("sat_done_at", done_at, 519);

        // Abort in the middle of the scan.
        eq_mode = 0;
        clear_obs();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 200) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_running", running, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        sticky_or = '0;
        repeat (4) step();
        check("abort_quiet", {25'd0, sticky_or & 7'b1111110}, 32'd0);

        // Clean restart; equal high around CLEAR/LOAD and after over.
        eq_mode = 3;
        clear_obs();
        start = 1'b1;
        step();
        start = 1'b0;
        run_to_done();
        check("r_clr_at", clr_at, 1);
        check("r_inc_cnt", inc_cnt, 3);
        check("r_first_inc", first_inc, 515);
        check("r_done_at", done_at, 519);
        check("r_sat", sat, 0);

        // Back-to-back: start held high through DONE.
        eq_mode = 1;
        clear_obs();
        start = 1'b1;
        step();
        run_to_done();
        check("b1_done_at", done_at, 519);
        check("b1_inc_cnt", inc_cnt, 3);
        eq_mode = 5;
        clear_obs();
        step();
        check("b2_done_one_cycle", done, 0);
        check("b2_clr_next", clrDp, 1);
        start = 1'b0;
        run_to_done();
        check("b2_inc_cnt", inc_cnt, 1);
        check("b2_done_at", done_at, 519);
        check("b2_sat", sat, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
